sfx_scheduler: RTL and testbench

Sequences the shared tone generator and volume path between background music (BGM) and three Tetris sound effects: piece drop, line clear, and game over. Sound-effect requests are queued and prioritised. The block fades BGM out on a 100 Hz tick, plays the selected effect's note sequence, then fades BGM back in. It sits between the music player / volume setting logic and the speaker tone generator, and supplies that generator's note divider and amplitude.

---
 rtl/sfx_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sfx_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: shares the tone generator between BGM and prioritised Tetris sound effects
module sfx_scheduler #(
    parameter logic [21:0] DROP_DIV   = 22'd191113,
    parameter logic [21:0] CLEAR_DIV0 = 22'd151686,
    parameter logic [21:0] CLEAR_DIV1 = 22'd127551,
    parameter logic [21:0] CLEAR_DIV2 = 22'd95556,
    parameter logic [21:0] OVER_DIV0  = 22'd127551,
    parameter logic [21:0] OVER_DIV1  = 22'd151686,
    parameter logic [21:0] OVER_DIV2  = 22'd191113,
    parameter logic [21:0] OVER_DIV3  = 22'd255102,
    parameter logic [3:0]  DROP_TICKS = 4'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        req_drop,
    input  logic        req_clear,
    input  logic        req_over,
    input  logic        bgm_en,
    input  logic [21:0] bgm_note_div,
    input  logic [15:0] master_amp,
    output logic [21:0] note_div,
    output logic [15:0] amplitude,
    output logic [1:0]  grant,
    output logic        sfx_active
);
    localparam logic [1:0] DROP  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] OVER  = 2'd3;

    typedef enum logic [1:0] {IDLE, FADE_OUT, PLAY, FADE_IN} state_t;

    state_t      state, state_n;
    logic [3:0]  gain, gain_n, tcnt, tcnt_n, dur;
    logic [1:0]  cur, cur_n, idx, idx_n, hi, last_idx;
    logic [3:1]  pending, pending_n, eff, clr;
    logic        go, play_n;
    logic [19:0] prod;
    logic [21:0] note_div_n;
    logic [15:0] amp_n;
    logic [1:0]  grant_n;

    function automatic logic [21:0] note_of(input logic [1:0] id, input logic [1:0] n);
        return id == OVER  ? (n == 2'd0 ? OVER_DIV0 : n == 2'd1 ? OVER_DIV1 : n == 2'd2 ? OVER_DIV2 : OVER_DIV3) :
               id == CLEAR ? (n == 2'd0 ? CLEAR_DIV0 : n == 2'd1 ? CLEAR_DIV1 : CLEAR_DIV2) : DROP_DIV;
    endfunction

    // Requests arriving this cycle take part in every decision, so a pulse acts on the next edge
    assign eff      = pending | {req_over, req_clear, req_drop};
    assign hi       = eff[3] ? OVER : eff[2] ? CLEAR : eff[1] ? DROP : 2'd0;
    assign dur      = cur == OVER ? 4'd10 : cur == CLEAR ? 4'd4 : DROP_TICKS;
    assign last_idx = cur == OVER ? 2'd3 : cur == CLEAR ? 2'd2 : 2'd0;

    // Next-state logic: fades, note sequencing, preemption and the request queue
    always_comb begin
        state_n = state;
        gain_n  = gain;
        cur_n   = cur;
        idx_n   = idx;
        tcnt_n  = tcnt;
        go      = 1'b0;
        unique case (state)
            IDLE: begin
                gain_n = 4'd8;
                if (|eff) begin
                    if (bgm_en) state_n = FADE_OUT;
                    else go = 1'b1;
                end
            end
            FADE_OUT: begin
                if (!bgm_en) begin
                    if (|eff) go = 1'b1;
                    else begin
                        state_n = IDLE;
                        gain_n  = 4'd8;
                    end
                end else if (gain == 4'd0 || (tick && gain == 4'd1)) go = 1'b1;
                else if (tick) gain_n = gain - 4'd1;
            end
            PLAY: begin
                if (hi > cur) go = 1'b1;
                else if (tick) begin
                    if (tcnt == dur - 4'd1) begin
                        tcnt_n = 4'd0;
                        if (idx == last_idx) begin
                            idx_n = 2'd0;
                            if (|eff) go = 1'b1;
                            else if (bgm_en) begin
                                state_n = FADE_IN;
                                gain_n  = 4'd0;
                            end else begin
                                state_n = IDLE;
                                gain_n  = 4'd8;
                            end
                        end else idx_n = idx + 2'd1;
                    end else tcnt_n = tcnt + 4'd1;
                end
            end
            FADE_IN: begin
                if (!bgm_en) begin
                    if (|eff) go = 1'b1;
                    else begin
                        state_n = IDLE;
                        gain_n  = 4'd8;
                    end
                end else if (|eff) begin
                    state_n = FADE_OUT;
                    gain_n  = (tick && gain < 4'd8) ? gain + 4'd1 : gain;
                end else if (tick) begin
                    gain_n = gain + 4'd1;
                    if (gain == 4'd7) state_n = IDLE;
                end
            end
        endcase
        if (go) begin
            state_n = PLAY;
            cur_n   = hi;
            idx_n   = 2'd0;
            tcnt_n  = 4'd0;
            gain_n  = 4'd0;
        end
        clr       = !go ? 3'b000 : hi == OVER ? 3'b100 : hi == CLEAR ? 3'b010 : hi == DROP ? 3'b001 : 3'b000;
        pending_n = eff & ~clr;
    end

    // Output values for the coming cycle, derived from the next state so they move with it
    always_comb begin
        play_n     = state_n == PLAY;
        prod       = 20'(master_amp) * 20'(gain_n);
        amp_n      = play_n ? master_amp : bgm_en ? prod[18:3] : 16'd0;
        note_div_n = play_n ? note_of(cur_n, idx_n) : bgm_note_div;
        grant_n    = play_n ? cur_n : 2'd0;
    end

    // State and registered outputs; reset abandons any effect and empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gain       <= 4'd8;
            cur        <= 2'd0;
            idx        <= 2'd0;
            tcnt       <= 4'd0;
            pending    <= 3'b000;
            note_div   <= 22'd0;
            amplitude  <= 16'd0;
            grant      <= 2'd0;
            sfx_active <= 1'b0;
        end else begin
            state      <= state_n;
            gain       <= gain_n;
            cur        <= cur_n;
            idx        <= idx_n;
            tcnt       <= tcnt_n;
            pending    <= pending_n;
            note_div   <= note_div_n;
            amplitude  <= amp_n;
            grant      <= grant_n;
            sfx_active <= play_n;
        end
    end
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: scoreboard bench checking every output change of sfx_scheduler against a directed script
module tb_sfx_scheduler;
    localparam logic [21:0] BDIV = 22'd100000;

    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic        req_drop = 1'b0, req_clear = 1'b0, req_over = 1'b0, bgm_en = 1'b0;
    logic [21:0] bgm_note_div = 22'd0;
    logic [15:0] master_amp = 16'd0;
    logic [21:0] note_div;
    logic [15:0] amplitude;
    logic [1:0]  grant;
    logic        sfx_active;

    int unsigned cyc = 0;
    int          n_chk = 0, n_fail = 0;
    string       scen = "reset";

    typedef struct packed {
        logic [31:0] c;
        logic [1:0]  g;
        logic        a;
        logic [21:0] d;
        logic [15:0] m;
    } exp_t;

    exp_t        q[$];
    logic [40:0] prev = '0;

    sfx_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick),
        .req_drop(req_drop), .req_clear(req_clear), .req_over(req_over),
        .bgm_en(bgm_en), .bgm_note_div(bgm_note_div), .master_amp(master_amp),
        .note_div(note_div), .amplitude(amplitude), .grant(grant), .sfx_active(sfx_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output tuple must match the next scripted expectation, in the right cycle
    always @(negedge clk) begin
        logic [40:0] now;
        exp_t        e;
        now = {grant, sfx_active, note_div, amplitude};
        if (now !== prev) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected_change cyc=%0d got g=%0d act=%0b div=%0d amp=%h", scen, cyc,
                         grant, sfx_active, note_div, amplitude);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || {e.g, e.a, e.d, e.m} !== now) begin
                    n_fail++;
                    $display("FAIL %s output_event got cyc=%0d g=%0d act=%0b div=%0d amp=%h want cyc=%0d g=%0d act=%0b div=%0d amp=%h",
                             scen, cyc, grant, sfx_active, note_div, amplitude, e.c, e.g, e.a, e.d, e.m);
                end
            end
            prev = now;
        end
    end

    task automatic check(input string nm, input logic [40:0] got, input logic [40:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic push_next(input logic [1:0] g, input logic a, input logic [21:0] d, input logic [15:0] m);
        exp_t e;
        e.c = cyc + 1;
        e.g = g;
        e.a = a;
        e.d = d;
        e.m = m;
        q.push_back(e);
    endtask

    task automatic drive(input logic t, input logic d, input logic c, input logic o);
        tick = t; req_drop = d; req_clear = c; req_over = o;
        @(negedge clk);
        tick = 1'b0; req_drop = 1'b0; req_clear = 1'b0; req_over = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_exp(input logic [1:0] g, input logic a, input logic [21:0] d, input logic [15:0] m);
        push_next(g, a, d, m);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fade_out_into(input logic [1:0] g, input logic [21:0] d);
        for (int k = 7; k >= 1; k--) tick_exp(2'd0, 1'b0, BDIV, 16'(k * 'h800));
        tick_exp(g, 1'b1, d, 16'h4000);
    endtask

    task automatic fade_in();
        for (int k = 1; k <= 7; k++) tick_exp(2'd0, 1'b0, BDIV, 16'(k * 'h800));
        tick_exp(2'd0, 1'b0, BDIV, 16'h4000);
    endtask

    task automatic over_rest();
        tick_exp(2'd3, 1'b1, 22'd151686, 16'h4000);
        ticks(9);
        tick_exp(2'd3, 1'b1, 22'd191113, 16'h4000);
        ticks(9);
        tick_exp(2'd3, 1'b1, 22'd255102, 16'h4000);
        ticks(9);
        tick_exp(2'd1, 1'b1, 22'd191113, 16'h4000);
        ticks(4);
        tick_exp(2'd0, 1'b0, BDIV, 16'h0000);
        fade_in();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {grant, sfx_active, note_div, amplitude}, 41'd0);
        rst = 1'b0;
        @(negedge clk);

        scen = "fade";
        push_next(2'd0, 1'b0, BDIV, 16'h4000);
        bgm_en = 1'b1; bgm_note_div = BDIV; master_amp = 16'h4000;
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        fade_out_into(2'd1, 22'd191113);
        ticks(4);
        tick_exp(2'd0, 1'b0, BDIV, 16'h0000);
        fade_in();

        scen = "preempt";
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        fade_out_into(2'd1, 22'd191113);
        ticks(2);
        push_next(2'd2, 1'b1, 22'd151686, 16'h4000);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        tick_exp(2'd2, 1'b1, 22'd127551, 16'h4000);
        ticks(3);
        tick_exp(2'd2, 1'b1, 22'd95556, 16'h4000);
        ticks(3);
        tick_exp(2'd0, 1'b0, BDIV, 16'h0000);
        fade_in();

        scen = "queue";
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        fade_out_into(2'd3, 22'd127551);
        ticks(9);
        over_rest();

        scen = "hold";
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        fade_out_into(2'd3, 22'd127551);
        ticks(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(6);
        over_rest();

        scen = "bgm_off";
        push_next(2'd0, 1'b0, BDIV, 16'h0000);
        bgm_en = 1'b0;
        repeat (2) @(negedge clk);
        push_next(2'd2, 1'b1, 22'd151686, 16'h4000);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(3);
        tick_exp(2'd2, 1'b1, 22'd127551, 16'h4000);
        ticks(3);
        tick_exp(2'd2, 1'b1, 22'd95556, 16'h4000);
        ticks(3);
        tick_exp(2'd0, 1'b0, BDIV, 16'h0000);

        scen = "reset_mid";
        master_amp = 16'h39FF;
        repeat (2) @(negedge clk);
        push_next(2'd3, 1'b1, 22'd127551, 16'h39FF);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        push_next(2'd0, 1'b0, 22'd0, 16'h0000);
        #2 rst = 1'b1;
        #1 check("async_reset", {grant, sfx_active, note_div, amplitude}, 41'd0);
        @(negedge clk);
        bgm_en = 1'b1;
        @(negedge clk);
        push_next(2'd0, 1'b0, BDIV, 16'h39FF);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ticks(3);
        repeat (4) @(negedge clk);

        scen = "drain";
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 41'(q.size()), 41'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
